// File: rtl/pkt_pkg.sv
// Shared constants and state encoding for the packet receive path.
// The shift-register stage upstream imports the same widths and sync value.
package pkt_pkg;

  // Packet geometry and framing
  localparam int PKT_W   = 64;
  localparam int SYNC_W  = 8;
  localparam logic [SYNC_W-1:0] SYNC_VAL = 8'hA5;

  // Longest run of idle cycles tolerated inside a packet
  localparam int GAP_MAX = 4;

  // Bit counter must be able to hold the value PKT_W
  localparam int CNT_W = $clog2(PKT_W + 1);

  // Deserializer states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // True when a packet's header does not carry the sync value
  function automatic logic hdr_bad(input logic [PKT_W-1:0] word);
    return word[PKT_W-1 -: SYNC_W] != SYNC_VAL;
  endfunction

endpackage

// File: rtl/pkt_gap_tmr.sv
// Saturating idle-cycle counter. 'expire' flags the idle cycle that would
// take the count past LIMIT, i.e. the (LIMIT+1)-th consecutive idle cycle.
module pkt_gap_tmr
  import pkt_pkg::*;
#(
  parameter int LIMIT = GAP_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 2);
  localparam logic [W-1:0] CNT_LIMIT = W'(LIMIT);
  localparam logic [W-1:0] CNT_SAT   = W'(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expire = en && (cnt == CNT_LIMIT);

  // Count idle cycles; clear has priority, count sticks at LIMIT+1
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled only at the clock edge), and all
    // state is updated with non-blocking assignments so every register sees
    // pre-edge values regardless of block ordering.
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_deser.sv
// Serial-to-parallel receive stage: assembles MSB-first packets, checks the
// sync header, aborts on long stalls and hands packets to the consumer
// through a single valid/ack holding register.
module pkt_deser
  import pkt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             bit_en,
  input  logic             pkt_ack,
  output logic [PKT_W-1:0] pkt_data,
  output logic             pkt_vld,
  output logic             hdr_err,
  output logic             gap_err,
  output logic             ovf_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [PKT_W-1:0] sreg;
  logic [PKT_W-1:0] word;
  logic             complete;
  logic             gap_abort;
  logic             gap_expire;
  logic             gap_en;
  logic             gap_clr;
  logic             accept;

  // Word as it stands after this cycle's bit is shifted in; on the final
  // bit this is the complete packet.
  assign word = {sreg[PKT_W-2:0], ser_in};

  assign busy    = (state == SHIFT);
  assign gap_en  = busy && !bit_en;
  assign gap_clr = !busy || bit_en;

  // The holding register can take a new packet if empty or emptied this edge
  assign accept = !pkt_vld || pkt_ack;

  pkt_gap_tmr #(
    .LIMIT(GAP_MAX)
  ) u_gap_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (gap_clr),
    .en    (gap_en),
    .expire(gap_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus completion / abort decode
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    complete  = 1'b0;
    gap_abort = 1'b0;
    case (state)
      IDLE: begin
        if (bit_en) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (bit_cnt == LAST_IDX) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (gap_expire) begin
          gap_abort = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter; a gap abort only needs the counter
  // cleared since the next packet overwrites every shift-register bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (bit_en) begin
      sreg    <= word;
      bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
    end else if (gap_abort) begin
      bit_cnt <= '0;
    end
  end

  // Holding register, handshake and error pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_data <= '0;
      pkt_vld  <= 1'b0;
      hdr_err  <= 1'b0;
      gap_err  <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      gap_err <= gap_abort;
      ovf_err <= complete && !accept;
      if (complete && accept) begin
        pkt_data <= word;
        pkt_vld  <= 1'b1;
        hdr_err  <= hdr_bad(word);
      end else if (pkt_vld && pkt_ack) begin
        pkt_vld <= 1'b0;
        hdr_err <= 1'b0;
      end
    end
  end

endmodule
